// File: rtl/pwm_run_ctrl_if.sv
// Bundle between the PWM register block (master) and the run sequencer (slave).
// The slave drives the run/armed/irq outputs plus a per-channel FSM state debug vector.
interface pwm_run_ctrl_if #(
   parameter int NPWM = 6,
   parameter int RPTW = 8
);
   logic [NPWM-1:0]      cfg_pwm_enb;
   logic [NPWM-1:0]      cfg_pwm_oneshot;
   logic [NPWM-1:0]      cfg_pwm_gpio_enb;
   logic [NPWM*RPTW-1:0] cfg_pwm_rpt;
   logic [NPWM-1:0]      sw_start;
   logic [NPWM-1:0]      sw_stop;
   logic                 sync_start;
   logic [NPWM-1:0]      pwm_os_done;
   logic [NPWM-1:0]      gpio_tgr;
   logic [NPWM-1:0]      irq_mask;
   logic [NPWM-1:0]      irq_clr;
   logic [NPWM-1:0]      pwm_run;
   logic [NPWM-1:0]      pwm_armed;
   logic [NPWM-1:0]      irq_stat;
   logic                 irq_o;
   logic [2*NPWM-1:0]    dbg_state;

   // Handshake: every input is either a level (cfg_*, irq_mask) or a single-cycle
   // pulse sampled on the rising edge of mclk; there is no valid/ready back-pressure.
   modport master (
      output cfg_pwm_enb, cfg_pwm_oneshot, cfg_pwm_gpio_enb, cfg_pwm_rpt,
      output sw_start, sw_stop, sync_start, pwm_os_done, gpio_tgr, irq_mask, irq_clr,
      input  pwm_run, pwm_armed, irq_stat, irq_o, dbg_state
   );

   modport slave (
      input  cfg_pwm_enb, cfg_pwm_oneshot, cfg_pwm_gpio_enb, cfg_pwm_rpt,
      input  sw_start, sw_stop, sync_start, pwm_os_done, gpio_tgr, irq_mask, irq_clr,
      output pwm_run, pwm_armed, irq_stat, irq_o, dbg_state
   );
endinterface

// File: rtl/pwm_run_ctrl.sv
// Per-channel IDLE/ARMED/RUN sequencer driving cfg_pwm_run of the PWM bank, with
// one-shot repeat counting and sticky maskable done interrupts.
module pwm_run_ctrl #(
   parameter int NPWM = 6,
   parameter int RPTW = 8
) (
   input  logic          mclk,
   input  logic          h_reset_n,
   pwm_run_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2
   } state_t;

   state_t          r_state     [NPWM];
   state_t          w_nxt_state [NPWM];
   logic [RPTW-1:0] r_cnt       [NPWM];
   logic [RPTW-1:0] w_nxt_cnt   [NPWM];
   logic [NPWM-1:0] r_run;
   logic [NPWM-1:0] r_armed;
   logic [NPWM-1:0] r_irq_stat;
   logic [NPWM-1:0] w_done;
   logic [NPWM-1:0] w_start;
   logic [NPWM-1:0] w_nxt_run;
   logic [NPWM-1:0] w_nxt_armed;

   assign w_start = bus.sw_start | {NPWM{bus.sync_start}};

   always_comb begin
      for (int i = 0; i < NPWM; i++) begin
         w_nxt_state[i] = r_state[i];
         w_nxt_cnt[i]   = r_cnt[i];
         w_done[i]      = 1'b0;
         if (!bus.cfg_pwm_enb[i] || bus.sw_stop[i]) begin
            w_nxt_state[i] = ST_IDLE;
            w_nxt_cnt[i]   = '0;
         end else begin
            unique case (r_state[i])
               ST_IDLE: begin
                  if (w_start[i]) begin
                     w_nxt_state[i] = bus.cfg_pwm_gpio_enb[i] ? ST_ARMED : ST_RUN;
                     w_nxt_cnt[i]   = '0;
                  end
               end
               ST_ARMED: begin
                  if (bus.gpio_tgr[i]) w_nxt_state[i] = ST_RUN;
               end
               ST_RUN: begin
                  // >= rather than == so a repeat value lowered mid-run finishes instead of wrapping
                  if (bus.pwm_os_done[i] && bus.cfg_pwm_oneshot[i]) begin
                     if (r_cnt[i] >= bus.cfg_pwm_rpt[i*RPTW +: RPTW]) begin
                        w_done[i]      = 1'b1;
                        w_nxt_cnt[i]   = '0;
                        w_nxt_state[i] = bus.cfg_pwm_gpio_enb[i] ? ST_ARMED : ST_IDLE;
                     end else begin
                        w_nxt_cnt[i] = r_cnt[i] + RPTW'(1);
                     end
                  end
               end
               default: begin
                  w_nxt_state[i] = ST_IDLE;
                  w_nxt_cnt[i]   = '0;
               end
            endcase
         end
      end
   end

   always_comb begin
      for (int i = 0; i < NPWM; i++) begin
         w_nxt_run[i]   = (w_nxt_state[i] == ST_RUN);
         w_nxt_armed[i] = (w_nxt_state[i] == ST_ARMED);
      end
   end

   always_ff @(posedge mclk or negedge h_reset_n) begin
      if (!h_reset_n) begin
         for (int i = 0; i < NPWM; i++) begin
            r_state[i] <= ST_IDLE;
            r_cnt[i]   <= '0;
         end
         r_run      <= '0;
         r_armed    <= '0;
         r_irq_stat <= '0;
      end else begin
         for (int i = 0; i < NPWM; i++) begin
            r_state[i] <= w_nxt_state[i];
            r_cnt[i]   <= w_nxt_cnt[i];
         end
         r_run      <= w_nxt_run;
         r_armed    <= w_nxt_armed;
         // a completion in the same cycle as its clear wins
         r_irq_stat <= (r_irq_stat & ~bus.irq_clr) | w_done;
      end
   end

   always_comb begin
      bus.dbg_state = '0;
      for (int i = 0; i < NPWM; i++) bus.dbg_state[2*i +: 2] = r_state[i];
   end

   assign bus.pwm_run   = r_run;
   assign bus.pwm_armed = r_armed;
   assign bus.irq_stat  = r_irq_stat;
   assign bus.irq_o     = |(r_irq_stat & bus.irq_mask);

endmodule

// File: tb/tb_pwm_run_ctrl.sv
// Scenario bench for pwm_run_ctrl: each test pushes expected {run,armed,stat,irq} per cycle
// into exp_q, the driver records observed outputs into obs_q, and the test drains both.
module tb_pwm_run_ctrl;
  localparam int NPWM = 6;
  localparam int RPTW = 8;
  localparam int W    = 3*NPWM + 1;

  logic mclk;
  logic h_reset_n;
  pwm_run_ctrl_if #(.NPWM(NPWM), .RPTW(RPTW)) bus ();

  pwm_run_ctrl #(.NPWM(NPWM), .RPTW(RPTW)) dut (
    .mclk      (mclk),
    .h_reset_n (h_reset_n),
    .bus       (bus)
  );

  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int vectors;
  int miscompares;

  // clock / reset
  initial begin
    mclk = 1'b0;
    forever #5 mclk = ~mclk;
  end

  function automatic logic [W-1:0] ev(logic [5:0] run, logic [5:0] armed, logic [5:0] stat, logic irq);
    return {run, armed, stat, irq};
  endfunction

  function automatic logic [W-1:0] sample();
    return {bus.pwm_run, bus.pwm_armed, bus.irq_stat, bus.irq_o};
  endfunction

  // driver tasks
  task automatic clear_pulses();
    bus.sw_start    = '0;
    bus.sw_stop     = '0;
    bus.sync_start  = 1'b0;
    bus.pwm_os_done = '0;
    bus.gpio_tgr    = '0;
    bus.irq_clr     = '0;
  endtask

  task automatic set_defaults();
    clear_pulses();
    bus.cfg_pwm_enb      = 6'h3F;
    bus.cfg_pwm_oneshot  = '0;
    bus.cfg_pwm_gpio_enb = '0;
    bus.cfg_pwm_rpt      = '0;
    bus.irq_mask         = '0;
  endtask

  task automatic set_rpt(input int ch, input logic [RPTW-1:0] val);
    bus.cfg_pwm_rpt[ch*RPTW +: RPTW] = val;
  endtask

  // Pulses set by the caller are seen on the next rising edge; outputs sampled 1ns later.
  task automatic tick(input logic [W-1:0] expv);
    exp_q.push_back(expv);
    @(posedge mclk);
    #1;
    obs_q.push_back(sample());
    clear_pulses();
  endtask

  task automatic test_reset();
    logic [W-1:0] e, o;
    int k;
    h_reset_n = 1'b0;
    set_defaults();
    repeat (3) @(posedge mclk);
    #1;
    exp_q.push_back(ev(6'h00, 6'h00, 6'h00, 1'b0));
    obs_q.push_back(sample());
    h_reset_n = 1'b1;
    tick(ev(6'h00, 6'h00, 6'h00, 1'b0));
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL reset[%0d] got {run,armed,stat,irq}=%05h exp=%05h", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_single_shot();
    logic [W-1:0] e, o;
    int k;
    bus.cfg_pwm_oneshot[0] = 1'b1;
    bus.irq_mask[0]        = 1'b1;
    set_rpt(0, 8'd0);
    bus.sw_start[0] = 1'b1;    tick(ev(6'h01, 6'h00, 6'h00, 1'b0));
                               tick(ev(6'h01, 6'h00, 6'h00, 1'b0));
    bus.pwm_os_done[0] = 1'b1; tick(ev(6'h00, 6'h00, 6'h01, 1'b1));
                               tick(ev(6'h00, 6'h00, 6'h01, 1'b1));
    bus.irq_clr[0] = 1'b1;     tick(ev(6'h00, 6'h00, 6'h00, 1'b0));
    set_defaults();
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL single_shot[%0d] got {run,armed,stat,irq}=%05h exp=%05h", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_repeat();
    logic [W-1:0] e, o;
    int k;
    int rpt;
    // random small repeat, then the 255 boundary (256 shots, no wrap)
    for (int pass = 0; pass < 2; pass++) begin
      rpt = (pass == 0) ? int'($urandom_range(1, 6)) : 255;
      bus.cfg_pwm_oneshot[1] = 1'b1;
      set_rpt(1, RPTW'(rpt));
      bus.sw_start[1] = 1'b1; tick(ev(6'h02, 6'h00, 6'h00, 1'b0));
      for (int n = 0; n < rpt; n++) begin
        bus.pwm_os_done[1] = 1'b1; tick(ev(6'h02, 6'h00, 6'h00, 1'b0));
      end
      bus.pwm_os_done[1] = 1'b1; tick(ev(6'h00, 6'h00, 6'h02, 1'b0));
      bus.irq_clr[1] = 1'b1;     tick(ev(6'h00, 6'h00, 6'h00, 1'b0));
      set_defaults();
    end
    // lowering the repeat below the current count finishes on the next done
    bus.cfg_pwm_oneshot[5] = 1'b1;
    set_rpt(5, 8'd5);
    bus.sw_start[5] = 1'b1; tick(ev(6'h20, 6'h00, 6'h00, 1'b0));
    for (int n = 0; n < 3; n++) begin
      bus.pwm_os_done[5] = 1'b1; tick(ev(6'h20, 6'h00, 6'h00, 1'b0));
    end
    set_rpt(5, 8'd1);
    bus.pwm_os_done[5] = 1'b1; tick(ev(6'h00, 6'h00, 6'h20, 1'b0));
    bus.irq_clr[5] = 1'b1;     tick(ev(6'h00, 6'h00, 6'h00, 1'b0));
    set_defaults();
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL repeat[%0d] got {run,armed,stat,irq}=%05h exp=%05h", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_gpio_arm();
    logic [W-1:0] e, o;
    int k;
    bus.cfg_pwm_oneshot[2]  = 1'b1;
    bus.cfg_pwm_gpio_enb[2] = 1'b1;
    bus.irq_mask[2]         = 1'b1;
    bus.sw_start[2] = 1'b1;    tick(ev(6'h00, 6'h04, 6'h00, 1'b0));
    bus.pwm_os_done[2] = 1'b1; tick(ev(6'h00, 6'h04, 6'h00, 1'b0));
    bus.gpio_tgr[2] = 1'b1;    tick(ev(6'h04, 6'h00, 6'h00, 1'b0));
    bus.gpio_tgr[2] = 1'b1;    tick(ev(6'h04, 6'h00, 6'h00, 1'b0));
    bus.pwm_os_done[2] = 1'b1; tick(ev(6'h00, 6'h04, 6'h04, 1'b1));
    bus.gpio_tgr[2] = 1'b1;    tick(ev(6'h04, 6'h00, 6'h04, 1'b1));
    bus.sw_stop[2] = 1'b1;     tick(ev(6'h00, 6'h00, 6'h04, 1'b1));
    bus.irq_clr[2] = 1'b1;     tick(ev(6'h00, 6'h00, 6'h00, 1'b0));
    set_defaults();
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL gpio_arm[%0d] got {run,armed,stat,irq}=%05h exp=%05h", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_sync_start();
    logic [W-1:0] e, o;
    int k;
    bus.sync_start = 1'b1;        tick(ev(6'h3F, 6'h00, 6'h00, 1'b0));
    bus.pwm_os_done = 6'h3F;      tick(ev(6'h3F, 6'h00, 6'h00, 1'b0));
    bus.cfg_pwm_enb[3] = 1'b0;    tick(ev(6'h37, 6'h00, 6'h00, 1'b0));
    bus.sync_start = 1'b1;        tick(ev(6'h37, 6'h00, 6'h00, 1'b0));
    bus.sw_stop = 6'h3F;          tick(ev(6'h00, 6'h00, 6'h00, 1'b0));
    bus.cfg_pwm_enb = 6'h3F;      tick(ev(6'h00, 6'h00, 6'h00, 1'b0));
    // back-to-back: different channels start through different paths in one cycle
    bus.cfg_pwm_gpio_enb = 6'h02;
    bus.sw_start = 6'h03;         tick(ev(6'h01, 6'h02, 6'h00, 1'b0));
    bus.gpio_tgr = 6'h02;
    bus.sw_stop  = 6'h01;         tick(ev(6'h02, 6'h00, 6'h00, 1'b0));
    bus.sw_stop  = 6'h3F;         tick(ev(6'h00, 6'h00, 6'h00, 1'b0));
    set_defaults();
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL sync_start[%0d] got {run,armed,stat,irq}=%05h exp=%05h", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_corners();
    logic [W-1:0] e, o;
    int k;
    bus.cfg_pwm_oneshot[4] = 1'b1;
    bus.sw_start[4] = 1'b1; bus.sw_stop[4] = 1'b1;     tick(ev(6'h00, 6'h00, 6'h00, 1'b0));
    bus.sw_start[4] = 1'b1;                            tick(ev(6'h10, 6'h00, 6'h00, 1'b0));
    bus.pwm_os_done[4] = 1'b1; bus.irq_clr[4] = 1'b1;  tick(ev(6'h00, 6'h00, 6'h10, 1'b0));
    bus.irq_mask[4] = 1'b1;
    bus.sw_start[4] = 1'b1;                            tick(ev(6'h10, 6'h00, 6'h10, 1'b1));
    bus.cfg_pwm_enb[4] = 1'b0;                         tick(ev(6'h00, 6'h00, 6'h10, 1'b1));
    bus.irq_mask[4] = 1'b0;                            tick(ev(6'h00, 6'h00, 6'h10, 1'b0));
    bus.irq_clr = 6'h2F;                               tick(ev(6'h00, 6'h00, 6'h10, 1'b0));
    bus.irq_clr[4] = 1'b1;                             tick(ev(6'h00, 6'h00, 6'h00, 1'b0));
    set_defaults();
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL corners[%0d] got {run,armed,stat,irq}=%05h exp=%05h", k, o, e);
      end
      k++;
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] e, o;
    int k;
    bus.cfg_pwm_oneshot[0]  = 1'b1;
    bus.cfg_pwm_gpio_enb[2] = 1'b1;
    bus.irq_mask            = 6'h3F;
    bus.sw_start = 6'h07;      tick(ev(6'h03, 6'h04, 6'h00, 1'b0));
    bus.pwm_os_done[0] = 1'b1; tick(ev(6'h02, 6'h04, 6'h01, 1'b1));
    bus.sw_start[0] = 1'b1;    tick(ev(6'h03, 6'h04, 6'h01, 1'b1));
    #2;
    h_reset_n = 1'b0;
    #1;
    exp_q.push_back(ev(6'h00, 6'h00, 6'h00, 1'b0));
    obs_q.push_back(sample());
    @(negedge mclk);
    h_reset_n = 1'b1;
    tick(ev(6'h00, 6'h00, 6'h00, 1'b0));
    set_defaults();
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin
        miscompares++;
        $display("FAIL async_reset[%0d] got {run,armed,stat,irq}=%05h exp=%05h", k, o, e);
      end
      k++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_single_shot();
    test_repeat();
    test_gpio_arm();
    test_sync_start();
    test_corners();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
